// File: rtl/bit_serializer_pkg.sv
// Shared types and sizing helpers for the bit serializer.
package bit_serializer_pkg;

    // Two-state frame controller.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Width of the bits-remaining counter; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: loads a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per clock, back-to-back without gaps.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             frame_done
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             x_q,     x_d;
    logic             xv_q,    xv_d;
    logic             accept;

    // First bit / remainder of a freshly loaded word, and the next bit /
    // remainder while shifting. shreg holds only the bits not yet on x.
    logic             load_bit;
    logic [WIDTH-1:0] load_rest;
    logic             shift_bit;
    logic [WIDTH-1:0] shift_rest;

    generate
        if (MSB_FIRST) begin : g_msb
            assign load_bit   = din[WIDTH-1];
            assign load_rest  = {din[WIDTH-2:0], 1'b0};
            assign shift_bit  = shreg_q[WIDTH-1];
            assign shift_rest = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign load_bit   = din[0];
            assign load_rest  = {1'b0, din[WIDTH-1:1]};
            assign shift_bit  = shreg_q[0];
            assign shift_rest = {1'b0, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    // Ready whenever idle or presenting the last bit, so words chain with no bubble.
    assign din_ready  = (state_q == ST_IDLE) || (cnt_q == '0);
    assign accept     = din_valid && din_ready;
    // Last bit of the frame is on x exactly when the counter reads zero.
    assign frame_done = (state_q == ST_SHIFT) && (cnt_q == '0);
    assign x          = x_q;
    assign x_valid    = xv_q;

    // Next-state: load on accept, shift while bits remain, else fall back to idle.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        xv_d    = xv_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    shreg_d = load_rest;
                    cnt_d   = CNT_LAST;
                    x_d     = load_bit;
                    xv_d    = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    shreg_d = shift_rest;
                    cnt_d   = cnt_q - CW'(1);
                    x_d     = shift_bit;
                end else if (accept) begin
                    shreg_d = load_rest;
                    cnt_d   = CNT_LAST;
                    x_d     = load_bit;
                    xv_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    shreg_d = '0;
                    x_d     = IDLE_BIT;
                    xv_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                shreg_d = '0;
                cnt_d   = '0;
                x_d     = IDLE_BIT;
                xv_d    = 1'b0;
            end
        endcase
    end

    // State, shift register, counter and output flops; reset aborts any frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            x_q     <= IDLE_BIT;
            xv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
        end
    end

endmodule
